// File: rtl/core_ctrl_if.sv
// Instruction- and data-memory handshakes between the core sequencer
// and its memories.
interface core_ctrl_if;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ready;
    logic [31:0] imem_rdata;
    logic        dmem_req;
    logic        dmem_we;
    logic [1:0]  dmem_width;
    logic [31:0] dmem_addr;
    logic        dmem_ready;

    modport master (
        output imem_req, imem_addr,
        input  imem_ready, imem_rdata,
        output dmem_req, dmem_we, dmem_width, dmem_addr,
        input  dmem_ready
    );

    modport slave (
        input  imem_req, imem_addr,
        output imem_ready, imem_rdata,
        input  dmem_req, dmem_we, dmem_width, dmem_addr,
        output dmem_ready
    );
endinterface

// File: rtl/core_ctrl.sv
// Multi-cycle RV32I sequencer: fetch, decode, execute, memory, writeback,
// with PC ownership, retire counting and halt-on-fault.
module core_ctrl #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst_n,
    core_ctrl_if.master bus,
    output logic [31:0] instr,
    input  logic        reg_write,
    input  logic        mem_read,
    input  logic        mem_write,
    input  logic        is_branch,
    input  logic        is_jump,
    input  logic        is_jalr,
    input  logic [1:0]  mem_width,
    input  logic        illegal,
    input  logic        branch_taken,
    input  logic [31:0] alu_result,
    input  logic [31:0] imm,
    output logic        rf_we,
    output logic [1:0]  wb_sel,
    output logic [31:0] pc,
    output logic        halted,
    output logic [31:0] retire_cnt
);

    typedef enum logic [2:0] {
        IDLE, FETCH, DECODE, EXEC, MEM, WB, HALT
    } state_t;

    state_t      state, state_n;
    logic [31:0] npc, npc_calc;
    logic [31:0] daddr;
    logic [1:0]  dwidth;
    logic        dwe;
    logic        is_mem, misaligned, fault;

    assign is_mem = mem_read | mem_write;

    always_comb begin
        if (is_jump)
            npc_calc = pc + imm;
        else if (is_jalr)
            npc_calc = alu_result & ~32'd1;
        else if (is_branch && branch_taken)
            npc_calc = pc + imm;
        else
            npc_calc = pc + 32'd4;
    end

    assign misaligned = (mem_width == 2'b01 && alu_result[0])
                     || (mem_width == 2'b10 && alu_result[1:0] != 2'b00);
    assign fault = (npc_calc[1:0] != 2'b00) || (is_mem && misaligned);

    always_comb begin
        state_n = state;
        unique case (state)
            IDLE:    state_n = FETCH;
            FETCH:   if (bus.imem_ready) state_n = DECODE;
            DECODE:  state_n = illegal ? HALT : EXEC;
            EXEC: begin
                if (fault)
                    state_n = HALT;
                else if (is_mem)
                    state_n = MEM;
                else
                    state_n = WB;
            end
            MEM:     if (bus.dmem_ready) state_n = dwe ? FETCH : WB;
            WB:      state_n = FETCH;
            HALT:    state_n = HALT;
            default: state_n = HALT;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            pc         <= RESET_PC;
            npc        <= RESET_PC;
            instr      <= 32'h0000_0013;
            daddr      <= 32'd0;
            dwidth     <= 2'b00;
            dwe        <= 1'b0;
            retire_cnt <= 32'd0;
        end else begin
            state <= state_n;
            unique case (state)
                FETCH: if (bus.imem_ready) instr <= bus.imem_rdata;
                EXEC: begin
                    npc <= npc_calc;
                    if (!fault && is_mem) begin
                        daddr  <= alu_result;
                        dwidth <= mem_width;
                        dwe    <= mem_write;
                    end
                end
                MEM: begin
                    // Stores retire straight out of MEM; loads still need WB.
                    if (bus.dmem_ready && dwe) begin
                        pc         <= npc;
                        retire_cnt <= retire_cnt + 32'd1;
                    end
                end
                WB: begin
                    pc         <= npc;
                    retire_cnt <= retire_cnt + 32'd1;
                end
                default: ;
            endcase
        end
    end

    assign bus.imem_req   = (state == FETCH);
    assign bus.imem_addr  = pc;
    assign bus.dmem_req   = (state == MEM);
    assign bus.dmem_we    = dwe;
    assign bus.dmem_width = dwidth;
    assign bus.dmem_addr  = daddr;
    assign halted         = (state == HALT);
    assign rf_we          = (state == WB) && reg_write;

    always_comb begin
        wb_sel = 2'b00;
        if (state == WB) begin
            if (mem_read)
                wb_sel = 2'b01;
            else if (is_jump || is_jalr)
                wb_sel = 2'b10;
        end
    end

endmodule
